sc_fetch_unit: RTL
==================

Name: sc_fetch_unit

Overview:
- Instruction-fetch stage directly upstream of the processor controller/decoder.
- Owns the PC, fetches 32-bit instruction words over a req/ack instruction bus, and buffers them in a 2-entry queue.
- Presents the 8-bit opcode plus register/immediate fields, with a valid/ready handshake, to the decode and control stage.
- Accepts a redirect (taken branch, JAL) from execute, which flushes buffered and in-flight instructions.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded at reset.
- ADDR_W, 32, PC and bus address width.
- QDEPTH, 2, instruction queue entries; must be a power of 2, ≥ 2.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- reset_n  in  1  asynchronous active-low reset.
- imem_req  out  1  fetch request valid.
- imem_addr  out  ADDR_W  byte address of the requested word.
- imem_gnt  in  1  request accepted this cycle when imem_req=1.
- imem_rvalid  in  1  read data returned; arrives ≥1 cycle after the grant, in order.
- imem_rdata  in  32  instruction word.
- redirect_valid  in  1  PC redirect from execute.
- redirect_pc  in  ADDR_W  redirect target.
- inst_valid  out  1  queue head holds a valid instruction.
- inst_ready  in  1  decode consumes the head.
- opcode  out  8  inst[31:24].
- rd  out  4  inst[23:20].
- rs1  out  4  inst[19:16].
- rs2  out  4  inst[15:12].
- imm  out  16  inst[15:0].
- inst_pc  out  ADDR_W  address of the head instruction.
- pc_plus4  out  ADDR_W  inst_pc + 4, for JAL link and branch base.

Behaviour:
Reset (async assert, sync deassert in the system):
- fetch_pc = RESET_PC; queue empty; outstanding = 0; discard = 0.
- imem_req = 0, inst_valid = 0. All field outputs 0.

Request issue:
- imem_req = 1 when (queue count + outstanding) < QDEPTH, no request is outstanding, and redirect_valid = 0.
- imem_addr = fetch_pc.
- On imem_req & imem_gnt: outstanding <= 1 and fetch_pc <= fetch_pc + 4 (wraps modulo 2^ADDR_W).
- imem_req and imem_addr hold stable until granted; they are not retracted unless a redirect occurs.
- At most one outstanding request.

Response handling:
- On imem_rvalid: outstanding <= 0.
- If discard = 0, push {imem_rdata, req_pc} into the queue. req_pc is latched at grant.
- If discard = 1, drop the word and clear discard.
- Space for the push is guaranteed by the issue rule; push to a full queue is an assertion failure.

Output handshake:
- Fields decode combinationally from the queue head.
- Pop on inst_valid & inst_ready.
- Same-cycle pop and push are allowed at any occupancy, including full, and keep the count unchanged.
- First instruction after reset appears no earlier than 2 cycles after the grant (1-cycle memory plus 1 queue write cycle).
- Sustained throughput is 1 instruction per 2 cycles with a 1-cycle memory.

Redirect (highest priority, 1 cycle):
- Queue flushed: count = 0, inst_valid = 0 next cycle.
- fetch_pc <= redirect_pc.
- If outstanding = 1 and imem_rvalid is not asserted in the same cycle, set discard = 1.
- If imem_rvalid arrives in the redirect cycle, drop that word and leave discard = 0.
- Any pop in the redirect cycle is still honored by decode; the queue is empty afterwards regardless.
- imem_req = 0 during the redirect cycle; fetching from redirect_pc starts the next cycle.
- Back-to-back redirects: the last one wins.

Misalignment:
- redirect_pc[1:0] is forced to 0; no exception is raised.

Reset mid-transaction:
- All state clears immediately.
- A later imem_rvalid with no outstanding request is ignored.

Decomposition:
- Shared package: instruction field bit positions (OP_HI/LO, RD, RS1, RS2, IMM), RESET_PC default, instruction width constant 32.
- Sub-module fetch_queue: parameterised synchronous FIFO (push, pop, flush, count, head data) storing {pc, inst}.
- Top level holds the PC, outstanding/discard tracking and field decode.

Test Plan:
- Reset, then zero-wait memory returning words 0x90120004 at addr 0 and 0x00341000 at addr 4, with inst_ready=1 -> imem_addr sequence 0, 4, 8; opcode=0x90, rd=1, rs1=2, imm=0x0004, inst_pc=0, pc_plus4=4; then opcode=0x00, inst_pc=4.
- inst_ready=0 for 10 cycles -> exactly 2 entries buffered, imem_req=0, no further grants; releasing ready drains entries in order at pc 0, 4.
- Redirect to 0x100 while a request for addr 8 is outstanding -> the addr 8 response is dropped, next imem_addr = 0x100, first visible inst_pc = 0x100.
- Redirect in the same cycle as imem_rvalid -> that word is never presented and discard stays 0.
- imem_gnt held low for 5 cycles -> imem_req and imem_addr stay stable and fetch_pc does not advance.
- Assert reset_n=0 mid-fetch, then release -> imem_req=0 and inst_valid=0 while in reset; fetch restarts at RESET_PC; a stale rvalid after reset is ignored.

Source files
------------

// File: rtl/sc_fetch_unit_pkg.sv
// Shared constants and field layout for the instruction-fetch stage.
// Decode of the 32-bit word into opcode/register/immediate fields.
package sc_fetch_unit_pkg;

  localparam int INST_W = 32;

  localparam int OP_HI  = 31;
  localparam int OP_LO  = 24;
  localparam int RD_HI  = 23;
  localparam int RD_LO  = 20;
  localparam int RS1_HI = 19;
  localparam int RS1_LO = 16;
  localparam int RS2_HI = 15;
  localparam int RS2_LO = 12;
  localparam int IMM_HI = 15;
  localparam int IMM_LO = 0;

  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

  typedef struct packed {
    logic [7:0]  opcode;
    logic [3:0]  rd;
    logic [3:0]  rs1;
    logic [3:0]  rs2;
    logic [15:0] imm;
  } inst_fields_t;

  function automatic inst_fields_t decode_fields(
    input logic [INST_W-1:0] w
  );
    inst_fields_t f;
    f.opcode = w[OP_HI:OP_LO];
    f.rd     = w[RD_HI:RD_LO];
    f.rs1    = w[RS1_HI:RS1_LO];
    f.rs2    = w[RS2_HI:RS2_LO];
    f.imm    = w[IMM_HI:IMM_LO];
    return f;
  endfunction

endpackage

// File: rtl/sc_fetch_unit_fetch_queue.sv
// Small synchronous FIFO holding {pc, inst} entries between
// the instruction bus and decode; flush empties it in one cycle.
module fetch_queue
  import sc_fetch_unit_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int W     = 64,
  localparam int PW   = $clog2(DEPTH),
  localparam int CW   = PW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push_i,
  input  logic [W-1:0]  data_i,
  input  logic          pop_i,
  input  logic          flush_i,
  output logic [CW-1:0] count_o,
  output logic [W-1:0]  head_o
);

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_q;
  logic [PW-1:0] rd_q;
  logic [CW-1:0] cnt_q;
  logic          do_push;
  logic          do_pop;

  assign do_push = push_i & ~flush_i;
  assign do_pop  = pop_i & (cnt_q != '0) & ~flush_i;
  assign count_o = cnt_q;
  assign head_o  = mem_q[rd_q];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else if (flush_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + PW'(1);
      if (do_pop)  rd_q <= rd_q + PW'(1);
      cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= data_i;
  end

  // Pointers wrap by width, so a full-queue push is only legal with a pop
  a_no_overflow: assert property (
    @(posedge clk) disable iff (!rst_n)
    !(do_push && !do_pop && cnt_q == CW'(DEPTH))
  );

endmodule

// File: rtl/sc_fetch_unit.sv
// Fetch stage: owns the PC, issues one request at a time on the
// instruction bus and hands buffered words to decode.
module sc_fetch_unit
  import sc_fetch_unit_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEF),
  parameter int QDEPTH = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_gnt,
  input  logic              imem_rvalid,
  input  logic [31:0]       imem_rdata,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [7:0]        opcode,
  output logic [3:0]        rd,
  output logic [3:0]        rs1,
  output logic [3:0]        rs2,
  output logic [15:0]       imm,
  output logic [ADDR_W-1:0] inst_pc,
  output logic [ADDR_W-1:0] pc_plus4
);

  localparam int CW = $clog2(QDEPTH) + 1;
  localparam int EW = ADDR_W + INST_W;

  logic              started_q;
  logic              outst_q, outst_d;
  logic              discard_q, discard_d;
  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [ADDR_W-1:0] req_pc_q, req_pc_d;

  logic [CW-1:0]     q_count;
  logic [EW-1:0]     q_head;
  logic              fire, rsp, push, pop;
  logic [ADDR_W-1:0] head_pc;
  inst_fields_t      fld;
  logic              unused_lsb;

  assign unused_lsb = ^redirect_pc[1:0];

  assign imem_req  = started_q & ~outst_q & ~redirect_valid
                   & (q_count < CW'(QDEPTH));
  assign imem_addr = fetch_pc_q;
  assign fire      = imem_req & imem_gnt;
  assign rsp       = imem_rvalid & outst_q;
  assign push      = rsp & ~discard_q & ~redirect_valid;
  assign inst_valid = (q_count != '0);
  assign pop       = inst_valid & inst_ready;

  fetch_queue #(
    .DEPTH (QDEPTH),
    .W     (EW)
  ) u_queue (
    .clk     (clk),
    .rst_n   (reset_n),
    .push_i  (push),
    .data_i  ({req_pc_q, imem_rdata}),
    .pop_i   (pop),
    .flush_i (redirect_valid),
    .count_o (q_count),
    .head_o  (q_head)
  );

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    req_pc_d   = req_pc_q;
    outst_d    = outst_q;
    discard_d  = discard_q;
    if (rsp) begin
      outst_d   = 1'b0;
      discard_d = 1'b0;
    end
    // A word still in flight at redirect belongs to the old path
    if (redirect_valid) begin
      fetch_pc_d = {redirect_pc[ADDR_W-1:2], 2'b00};
      if (outst_q && !imem_rvalid) discard_d = 1'b1;
    end else if (fire) begin
      outst_d    = 1'b1;
      fetch_pc_d = fetch_pc_q + ADDR_W'(4);
      req_pc_d   = fetch_pc_q;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      started_q  <= 1'b0;
      outst_q    <= 1'b0;
      discard_q  <= 1'b0;
      fetch_pc_q <= RESET_PC;
      req_pc_q   <= RESET_PC;
    end else begin
      started_q  <= 1'b1;
      outst_q    <= outst_d;
      discard_q  <= discard_d;
      fetch_pc_q <= fetch_pc_d;
      req_pc_q   <= req_pc_d;
    end
  end

  assign head_pc = q_head[EW-1:INST_W];
  assign fld     = decode_fields(q_head[INST_W-1:0]);

  always_comb begin
    opcode   = '0;
    rd       = '0;
    rs1      = '0;
    rs2      = '0;
    imm      = '0;
    inst_pc  = '0;
    pc_plus4 = '0;
    if (inst_valid) begin
      opcode   = fld.opcode;
      rd       = fld.rd;
      rs1      = fld.rs1;
      rs2      = fld.rs2;
      imm      = fld.imm;
      inst_pc  = head_pc;
      pc_plus4 = head_pc + ADDR_W'(4);
    end
  end

endmodule
